// File: rtl/mdu_mult_seq_if.sv
// Operand, MTHI/MTLO and result bundle between the core and the multiply unit.
// The master drives the operands and writes; the slave returns busy, done and hi/lo.
interface mdu_mult_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_mult_seq.sv
// Sequential radix-2 MULT/MULTU with HI/LO; result WIDTH+1 cycles after start.
// No queueing: start and MTHI/MTLO are ignored while busy, so the core must stall.
module mdu_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mdu_mult_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes: -(2^(W-1)) negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // acc[2W] keeps the add carry so the upper half never overflows before the shift.
  always_comb begin
    sum     = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    acc_nxt = mplier[0] ? ({sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
    prod    = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end else begin
            if (bus.hi_we) bus.hi <= bus.wdata;
            if (bus.lo_we) bus.lo <= bus.wdata;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          bus.hi <= prod[2*WIDTH-1:WIDTH];
          bus.lo <= prod[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_mult_seq.sv
// Directed vectors for mdu_mult_seq; expected {hi,lo} pushed at issue, checked on done.
module tb_mdu_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [63:0] sb[$];

  mdu_mult_seq_if #(.WIDTH(32)) ifc ();

  mdu_mult_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("product", {ifc.hi, ifc.lo}, sb.pop_front());
      end
    end
  end

  task automatic wait_done(output int k);
    k = 0;
    while (!ifc.done && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ifc.is_signed = s;
    ifc.a = a;
    ifc.b = b;
    ifc.start = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int k;
    issue(s, a, b);
    sb.push_back(exp);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a = '1;
    ifc.b = '1;
    check({nm, "_busy"}, 64'(ifc.busy), 64'd1);
    wait_done(k);
    check({nm, "_latency"}, 64'(k), 64'd33);
    check({nm, "_busy_end"}, 64'(ifc.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    ifc.start = 1'b0;
    ifc.is_signed = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
    ifc.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst_done", 64'(ifc.done), 64'd0);
    check("rst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    rst_n = 1'b1;

    run_op("t1_signed", 1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("t2_unsigned", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("t2_signed", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("t3_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("t3_minone", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

    // Busy guards: second start and MTHI land mid-run and must vanish.
    issue(1'b0, 32'd2, 32'd3);
    sb.push_back(64'd6);
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    ifc.start = 1'b1;
    ifc.a = 32'd9;
    ifc.b = 32'd9;
    ifc.hi_we = 1'b1;
    ifc.wdata = 32'h55;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.hi_we = 1'b0;
    check("t4_hi_hold", 64'(ifc.hi), 64'hFFFF_FFFF);
    wait_done(k);
    check("t4_latency", 64'(k), 64'd28);
    repeat (40) @(negedge clk);
    check("t4_hi_after", 64'(ifc.hi), 64'd0);

    // Reset mid-operation.
    issue(1'b0, 32'd5, 32'd5);
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 64'(ifc.busy), 64'd0);
    check("t5_done", 64'(ifc.done), 64'd0);
    check("t5_hilo", {ifc.hi, ifc.lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_no_done_hilo", {ifc.hi, ifc.lo}, 64'd0);
    run_op("t5_rerun", 1'b0, 32'd5, 32'd5, 64'd25);

    // Back-to-back: start held across the done cycle.
    issue(1'b0, 32'd4, 32'd4);
    sb.push_back(64'd16);
    sb.push_back(64'd16);
    @(negedge clk);
    wait_done(k);
    check("t6_first", 64'(k), 64'd33);
    @(negedge clk);
    ifc.start = 1'b0;
    k++;
    check("t6_rerun_busy", 64'(ifc.busy), 64'd1);
    while (!ifc.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6_second", 64'(k), 64'd67);

    @(negedge clk);
    ifc.lo_we = 1'b1;
    ifc.wdata = 32'h1234;
    @(negedge clk);
    ifc.lo_we = 1'b0;
    check("t6_mtlo", {ifc.hi, ifc.lo}, 64'h0000_0000_0000_1234);
    ifc.hi_we = 1'b1;
    ifc.lo_we = 1'b1;
    ifc.wdata = 32'hABCD;
    @(negedge clk);
    ifc.hi_we = 1'b0;
    ifc.lo_we = 1'b0;
    check("both_we", {ifc.hi, ifc.lo}, 64'h0000_ABCD_0000_ABCD);

    // Start beats a same-cycle MTHI; hi holds through RUN.
    issue(1'b0, 32'd1, 32'd1);
    ifc.hi_we = 1'b1;
    ifc.wdata = 32'h77;
    sb.push_back(64'd1);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.hi_we = 1'b0;
    check("start_wins_hi", 64'(ifc.hi), 64'hABCD);
    wait_done(k);
    check("start_wins_latency", 64'(k), 64'd33);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
